// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver
//   Initiator side of a combinational ALU. Commands arrive over valid/ready,
//   operands and opcode are registered onto the ALU, and the result is sampled
//   one cycle later into an in-order response FIFO. Chained commands take
//   operand A from the last good result. Divide-by-zero is flagged per entry.
//
// Ports
//   clk, rst_n                    clock, async active-low reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_a, cmd_b, cmd_sel         operands and opcode
//   cmd_chain                     1: operand A = last_result
//   alu_a, alu_b, alu_sel         registered drive to the ALU
//   alu_out, alu_cout             ALU result and carry of a+b
//   rsp_valid/rsp_ready           response handshake (FIFO head)
//   rsp_data, rsp_cout, rsp_err   head entry, zero when empty
//   busy                          1 while an op is executing
module alu_cmd_driver #(
  parameter int WIDTH = 16,
  parameter int OPW   = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [OPW-1:0]   cmd_sel,
  input  logic             cmd_chain,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_cout,
  output logic             rsp_err,
  output logic             busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]  DEPTH_C  = CW'(DEPTH);
  localparam logic [OPW-1:0] SEL_DIV  = OPW'(3);   // a / b
  localparam logic [OPW-1:0] SEL_RDIV = OPW'(11);  // b / a

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             cout;
    logic             err;
  } rsp_t;

  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

  state_t                 state;
  logic [WIDTH-1:0]       last_result;
  rsp_t [DEPTH-1:0]       mem;
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count;

  logic div_err, push, pop;
  rsp_t push_ent, head;

  // Divide-by-zero is judged on the registered operands actually at the ALU,
  // so a chained A of zero is caught for the reverse divide too.
  always_comb begin
    div_err  = ((alu_sel == SEL_DIV)  && (alu_b == '0)) ||
               ((alu_sel == SEL_RDIV) && (alu_a == '0));
    push_ent = '{data: (div_err ? '0 : alu_out), cout: alu_cout, err: div_err};
    head     = mem[rd_ptr];
  end

  assign push      = (state == EXEC);
  assign pop       = rsp_valid && rsp_ready;
  assign busy      = (state == EXEC);
  // A command is only taken with a free slot, so EXEC can always push.
  assign cmd_ready = (state == IDLE) && (count < DEPTH_C);
  assign rsp_valid = (count != '0);
  assign rsp_data  = rsp_valid ? head.data : '0;
  assign rsp_cout  = rsp_valid ? head.cout : 1'b0;
  assign rsp_err   = rsp_valid ? head.err  : 1'b0;

  // Control FSM and ALU drive registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_sel     <= '0;
      last_result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            alu_a   <= cmd_chain ? last_result : cmd_a;
            alu_b   <= cmd_b;
            alu_sel <= cmd_sel;
            state   <= EXEC;
          end
        end
        EXEC: begin
          // Errored ops leave the chain source untouched.
          if (!div_err) last_result <= alu_out;
          state <= IDLE;
        end
      endcase
    end
  end

  // Response FIFO; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_ent;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_driver.sv
module tb_alu_cmd_driver;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready, cmd_chain;
  logic [15:0] cmd_a, cmd_b;
  logic [3:0]  cmd_sel;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_sel;
  logic        alu_cout;
  logic        rsp_valid, rsp_ready, rsp_cout, rsp_err, busy;
  logic [15:0] rsp_data;

  int n_tests = 0;
  int n_fail  = 0;

  alu_cmd_driver #(.WIDTH(16), .OPW(4), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .cmd_chain(cmd_chain),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_cout(rsp_cout), .rsp_err(rsp_err),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ALU the driver talks to
  function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [3:0] s);
    case (s)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a * b;
      4'd3:    return (b == 0) ? 16'hFFFF : a / b;
      4'd4:    return a & b;
      4'd5:    return a | b;
      4'd6:    return a ^ b;
      4'd7:    return ~a;
      4'd8:    return a << b[3:0];
      4'd9:    return a >> b[3:0];
      4'd10:   return {a[14:0], a[15]};
      4'd11:   return (a == 0) ? 16'hFFFF : b / a;
      4'd12:   return ~(a & b);
      4'd13:   return ~(a | b);
      4'd14:   return ~(a ^ b);
      default: return (a == b) ? 16'd1 : 16'd0;
    endcase
  endfunction

  function automatic logic carry_f(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16];
  endfunction

  assign alu_out  = alu_f(alu_a, alu_b, alu_sel);
  assign alu_cout = carry_f(alu_a, alu_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    logic [15:0] data;
    logic        cout;
    logic        err;
  } ent_t;

  ent_t        mq[$];       // results the DUT FIFO should hold
  bit          m_busy = 0;  // an op is in flight
  ent_t        m_ent;
  logic [15:0] m_a = 0, m_b = 0, mlast = 0;
  logic [3:0]  m_sel = 0;

  function automatic ent_t make_ent(input logic [15:0] a, input logic [15:0] b,
                                    input logic [3:0] s);
    ent_t e;
    e.err  = (s == 4'd3 && b == 0) || (s == 4'd11 && a == 0);
    e.data = e.err ? 16'h0 : alu_f(a, b, s);
    e.cout = carry_f(a, b);
    return e;
  endfunction

  // Inputs only change just after a rising edge, so the falling edge sees
  // stable outputs and the handshakes that the next rising edge will take.
  always @(negedge clk) begin
    bit exp_ready, exp_valid, do_pop, do_acc;
    if (!rst_n) begin
      mq.delete();
      m_busy = 0; m_a = 0; m_b = 0; m_sel = 0; mlast = 0;
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_cout", rsp_cout, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      chk("rst_alu_sel", alu_sel, 0);
    end else begin
      exp_ready = !m_busy && (mq.size() < 4);
      exp_valid = (mq.size() != 0);
      chk("cmd_ready", cmd_ready, exp_ready);
      chk("busy", busy, m_busy);
      chk("rsp_valid", rsp_valid, exp_valid);
      chk("rsp_data", rsp_data, exp_valid ? mq[0].data : 16'h0);
      chk("rsp_cout", rsp_cout, exp_valid ? mq[0].cout : 1'b0);
      chk("rsp_err", rsp_err, exp_valid ? mq[0].err : 1'b0);
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("alu_sel", alu_sel, m_sel);
      do_pop = exp_valid && rsp_ready;
      do_acc = cmd_valid && exp_ready;
      if (do_pop) void'(mq.pop_front());
      if (m_busy) begin
        mq.push_back(m_ent);
        if (!m_ent.err) mlast = m_ent.data;
        m_busy = 0;
      end
      if (do_acc) begin
        m_a    = cmd_chain ? mlast : cmd_a;
        m_b    = cmd_b;
        m_sel  = cmd_sel;
        m_ent  = make_ent(m_a, m_b, m_sel);
        m_busy = 1;
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_accept(input string name);
    bit ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    cmd_valid = 0;
    chk({name, "_accepted"}, ok, 1);
  endtask

  task automatic send(input string name, input logic [15:0] a, input logic [15:0] b,
                      input logic [3:0] s, input logic ch);
    cmd_a = a; cmd_b = b; cmd_sel = s; cmd_chain = ch; cmd_valid = 1;
    wait_accept(name);
  endtask

  // Wait for a head entry, check it against literals, then pop it.
  task automatic expect_head(input string name, input logic [15:0] d, input logic c,
                             input logic e, output int waited);
    bit ok = 0;
    waited = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      waited = k + 1;
      if (rsp_valid) begin ok = 1; break; end
    end
    chk({name, "_valid"}, ok, 1);
    if (ok) begin
      chk({name, "_data"}, rsp_data, d);
      chk({name, "_cout"}, rsp_cout, c);
      chk({name, "_err"}, rsp_err, e);
      @(posedge clk); #1 rsp_ready = 1;
      @(posedge clk); #1 rsp_ready = 0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    bit rdone;
    rst_n = 1; cmd_valid = 0; rsp_ready = 0;
    cmd_a = 0; cmd_b = 0; cmd_sel = 0; cmd_chain = 0;
    #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // 1: basic add and latency
    send("t1", 16'd3, 16'd5, 4'd0, 0);
    expect_head("t1", 16'h0008, 0, 0, w);
    chk("t1_latency", w, 2);

    // 2: carry out, subtract
    send("t2a", 16'hFFFF, 16'h0001, 4'd0, 0);
    expect_head("t2a", 16'h0000, 1, 0, w);
    send("t2b", 16'h0010, 16'h0004, 4'd1, 0);
    expect_head("t2b", 16'h000C, 0, 0, w);

    // 3: chain, cmd_a ignored
    send("t3a", 16'd10, 16'd4, 4'd1, 0);
    expect_head("t3a", 16'h0006, 0, 0, w);
    send("t3b", 16'd999, 16'd3, 4'd2, 1);
    chk("t3_alu_a", alu_a, 16'd6);
    expect_head("t3b", 16'h0012, 0, 0, w);

    // 4: divide by zero keeps last good result for chaining
    send("t4a", 16'd7, 16'd0, 4'd3, 0);
    expect_head("t4a", 16'h0000, 0, 1, w);
    send("t4b", 16'd55, 16'd1, 4'd0, 1);
    expect_head("t4b", 16'h0013, 0, 0, w);

    // 5: fill the FIFO, fifth command stalls until a pop
    for (int i = 1; i <= 4; i++) send("t5", 16'(i + 1), 16'(i), 4'd0, 0);
    cmd_a = 16'd6; cmd_b = 16'd5; cmd_sel = 4'd0; cmd_chain = 0; cmd_valid = 1;
    repeat (3) begin
      @(negedge clk);
      chk("t5_full_ready", cmd_ready, 0);
    end
    expect_head("t5_0", 16'd3, 0, 0, w);
    wait_accept("t5_fifth");
    expect_head("t5_1", 16'd5, 0, 0, w);
    expect_head("t5_2", 16'd7, 0, 0, w);
    expect_head("t5_3", 16'd9, 0, 0, w);
    expect_head("t5_4", 16'd11, 0, 0, w);

    // 6: reset mid-EXEC with two entries queued
    send("t6a", 16'd1, 16'd2, 4'd0, 0);
    send("t6b", 16'd3, 16'd4, 4'd0, 0);
    send("t6c", 16'd5, 16'd6, 4'd0, 0);
    chk("t6_busy_before", busy, 1);
    rst_n = 0;
    @(negedge clk);
    chk("t6_rsp_valid", rsp_valid, 0);
    chk("t6_alu_a", alu_a, 0);
    chk("t6_busy", busy, 0);
    @(posedge clk); #1 rst_n = 1;
    send("t6d", 16'd1, 16'd1, 4'd0, 0);
    expect_head("t6d", 16'h0002, 0, 0, w);
    send("t6e", 16'd50, 16'd7, 4'd0, 1);
    expect_head("t6e", 16'h0009, 0, 0, w);

    // Random traffic against the model
    rdone = 0;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          logic [15:0] ra, rb;
          ra = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom);
          rb = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom);
          send("rnd", ra, rb, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
        end
        rdone = 1;
      end
      begin
        while (!rdone) begin
          @(posedge clk); #1;
          rsp_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    rsp_ready = 1;
    repeat (10) @(posedge clk);
    #1 rsp_ready = 0;
    @(negedge clk);
    chk("drained", rsp_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
